// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared state encoding, default constants and helpers for the LIF neuron
package lif_pkg;

    typedef enum logic {
        ST_INTEGRATE  = 1'b0,
        ST_REFRACTORY = 1'b1
    } lif_state_t;

    localparam int DEF_V_SIZE     = 8;
    localparam int DEF_N_IN       = 4;
    localparam int DEF_THRESHOLD  = 64;
    localparam int DEF_V_LEAK     = 1;
    localparam int DEF_REFRAC     = 2;
    localparam int DEF_RESET_MODE = 0;

    // Largest membrane voltage representable in V_SIZE-1 unsigned bits.
    function automatic int vmax(input int v_size);
        return (1 << (v_size - 1)) - 1;
    endfunction

    // A zero-length refractory period still needs a one-bit counter.
    function automatic int cnt_width(input int refrac);
        return (refrac > 0) ? $clog2(refrac + 1) : 1;
    endfunction

endpackage

// File: rtl/lif_syn_sum.sv
// rtl/lif_syn_sum.sv - combinational saturating sum of the weights of spiking synapses
module lif_syn_sum
    import lif_pkg::*;
#(
    parameter int V_SIZE = DEF_V_SIZE,
    parameter int N_IN   = DEF_N_IN
) (
    input  logic [N_IN-1:0]        spike_in,
    input  logic [N_IN*V_SIZE-1:0] weights,
    output logic [V_SIZE-1:0]      syn_sum
);

    localparam logic signed [V_SIZE:0] C_SMAX = (V_SIZE+1)'(vmax(V_SIZE));
    localparam logic signed [V_SIZE:0] C_SMIN = ~C_SMAX;

    logic signed [V_SIZE:0]   w_acc;
    logic signed [V_SIZE-1:0] w_wt;

    // One guard bit keeps each partial sum exact before it is clipped back.
    always_comb begin
        w_acc = '0;
        w_wt  = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_wt = $signed(weights[i*V_SIZE +: V_SIZE]);
            if (spike_in[i]) begin
                w_acc = w_acc + (V_SIZE+1)'(w_wt);
                if (w_acc > C_SMAX) begin
                    w_acc = C_SMAX;
                end else if (w_acc < C_SMIN) begin
                    w_acc = C_SMIN;
                end
            end
        end
    end

    assign syn_sum = w_acc[V_SIZE-1:0];

endmodule

// File: rtl/lif_neuron_multi.sv
// rtl/lif_neuron_multi.sv - multi-input leaky integrate-and-fire neuron with refractory period
module lif_neuron_multi
    import lif_pkg::*;
#(
    parameter int V_SIZE     = DEF_V_SIZE,
    parameter int N_IN       = DEF_N_IN,
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int V_LEAK     = DEF_V_LEAK,
    parameter int REFRAC     = DEF_REFRAC,
    parameter int RESET_MODE = DEF_RESET_MODE
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic [N_IN-1:0]        spike_in,
    input  logic [N_IN*V_SIZE-1:0] weights,
    output logic                   spike_out,
    output logic [V_SIZE-2:0]      voltage,
    output logic                   refrac_busy
);

    localparam int                     CW       = cnt_width(REFRAC);
    localparam logic signed [V_SIZE:0] C_LEAK   = (V_SIZE+1)'(V_LEAK);
    localparam logic signed [V_SIZE:0] C_VMAX   = (V_SIZE+1)'(vmax(V_SIZE));
    localparam logic [V_SIZE-2:0]      C_THR    = (V_SIZE-1)'(THRESHOLD);
    localparam logic [CW-1:0]          C_REFRAC = CW'(REFRAC);

    lif_state_t              r_state, w_state_nxt;
    logic [V_SIZE-2:0]       r_voltage, w_voltage_nxt;
    logic [CW-1:0]           r_cnt, w_cnt_nxt;
    logic                    r_spike, w_spike_nxt;

    logic [V_SIZE-1:0]       w_syn_sum;
    logic signed [V_SIZE:0]  w_raw;
    logic [V_SIZE-2:0]       w_next;

    lif_syn_sum #(
        .V_SIZE (V_SIZE),
        .N_IN   (N_IN)
    ) u_syn_sum (
        .spike_in (spike_in),
        .weights  (weights),
        .syn_sum  (w_syn_sum)
    );

    // Voltage is non-negative, so zero-extend it; the synaptic sum is signed.
    assign w_raw = $signed({2'b00, r_voltage})
                 + (V_SIZE+1)'($signed(w_syn_sum))
                 - C_LEAK;

    always_comb begin
        w_next = w_raw[V_SIZE-2:0];
        if (w_raw[V_SIZE]) begin
            w_next = '0;
        end else if (w_raw > C_VMAX) begin
            w_next = '1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_voltage_nxt = r_voltage;
        w_cnt_nxt     = r_cnt;
        w_spike_nxt   = 1'b0;
        if (en) begin
            case (r_state)
                ST_INTEGRATE: begin
                    if (w_next >= C_THR) begin
                        w_spike_nxt   = 1'b1;
                        w_voltage_nxt = (RESET_MODE == 1) ? (w_next - C_THR) : '0;
                        w_cnt_nxt     = C_REFRAC;
                        w_state_nxt   = (REFRAC > 0) ? ST_REFRACTORY : ST_INTEGRATE;
                    end else begin
                        w_voltage_nxt = w_next;
                    end
                end
                ST_REFRACTORY: begin
                    // Inputs and leak are ignored; only the countdown advances.
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                    if (r_cnt <= CW'(1)) begin
                        w_state_nxt = ST_INTEGRATE;
                    end
                end
                default: begin
                    w_state_nxt = ST_INTEGRATE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_INTEGRATE;
            r_voltage <= '0;
            r_cnt     <= '0;
            r_spike   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_voltage <= w_voltage_nxt;
            r_cnt     <= w_cnt_nxt;
            r_spike   <= w_spike_nxt;
        end
    end

    assign spike_out   = r_spike;
    assign voltage     = r_voltage;
    assign refrac_busy = (r_state == ST_REFRACTORY);

endmodule

// File: doc/lif_neuron_multi.md
LIF_NEURON_MULTI -- requirements
Module: lif_neuron_multi

Interface
REQ-001 SHALL have parameter V_SIZE, default 8: signed datapath width; membrane voltage is unsigned V_SIZE-1 bits (VMAX = 2^(V_SIZE-1)-1).
REQ-002 SHALL have parameter N_IN, default 4: number of synaptic inputs (1..16).
REQ-003 SHALL have parameter THRESHOLD, default 64: firing threshold, legal range 1..VMAX.
REQ-004 SHALL have parameter V_LEAK, default 1: leak subtracted per enabled step, legal range 0..VMAX.
REQ-005 SHALL have parameter REFRAC, default 2: refractory length in enabled steps; 0 disables refractory.
REQ-006 SHALL have parameter RESET_MODE, default 0: 0 = voltage to zero on fire; 1 = voltage minus THRESHOLD on fire.
REQ-007 SHALL have port clk, input, 1: single clock, rising edge.
REQ-008 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port en, input, 1: time-step enable; state advances only on edges with en=1.
REQ-010 SHALL have port spike_in, input, N_IN: one spike bit per synapse.
REQ-011 SHALL have port weights, input, N_IN*V_SIZE: packed signed weights; synapse i at bits [i*V_SIZE +: V_SIZE].
REQ-012 SHALL have port spike_out, output, 1: registered one-cycle fire pulse.
REQ-013 SHALL have port voltage, output, V_SIZE-1: current membrane voltage register.
REQ-014 SHALL have port refrac_busy, output, 1: high while in REFRACTORY state.

Function
REQ-015 SHALL form syn_sum = saturating signed sum of weights[i] for every i with spike_in[i]=1, clipped to [-2^(V_SIZE-1), VMAX] after every addition; syn_sum = 0 if no bit set.
REQ-016 SHALL compute next = voltage + syn_sum - V_LEAK at V_SIZE+1 bits, then clamp to [0, VMAX].
REQ-017 SHALL implement two states: INTEGRATE and REFRACTORY.
REQ-018 SHALL, in INTEGRATE on an enabled edge with next >= THRESHOLD, set spike_out=1, voltage = 0 (RESET_MODE 0) or next-THRESHOLD (RESET_MODE 1), load refractory counter with REFRAC, and go to REFRACTORY if REFRAC>0, else stay in INTEGRATE.
REQ-019 SHALL, in INTEGRATE on an enabled edge with next < THRESHOLD, set voltage = next and spike_out=0.
REQ-020 SHALL, in REFRACTORY on each enabled edge, ignore spike_in, hold voltage, apply no leak, decrement the counter, and return to INTEGRATE on the edge where the counter reaches 0.
REQ-021 SHALL clear spike_out on every edge where no fire occurs, including all edges with en=0; en=0 holds voltage, state and counter.
REQ-022 SHALL make the fire decision on the same edge that samples the inputs; spike_out and the voltage update appear together one cycle after the sampled inputs (latency 1).
REQ-023 SHALL treat next == THRESHOLD as a fire.
REQ-024 SHALL size the refractory counter as clog2(REFRAC+1) bits, minimum 1.

Reset
REQ-025 SHALL, while rstn=0, immediately and without a clock edge force voltage=0, spike_out=0, counter=0, state=INTEGRATE; this applies equally during REFRACTORY.
REQ-026 SHALL resume integration on the first enabled edge after rstn deasserts.

Structure
REQ-027 SHALL take state encoding, default parameter constants and the VMAX helper from shared package lif_pkg.
REQ-028 SHALL implement the saturating weighted sum as sub-module lif_syn_sum (combinational, parametrised by V_SIZE and N_IN).

Verification (V_SIZE=8, N_IN=4, THRESHOLD=64, V_LEAK=1, REFRAC=2)
REQ-029 SHALL test integrate/fire: weights {40,30,20,10} (i=3..0), spike_in=4'b0011, en=1 -> voltage 29, 58, then spike_out=1 with voltage 0; 2 refractory steps with refrac_busy=1 and voltage 0; next step voltage 29.
REQ-030 SHALL test saturation with RESET_MODE=1: all weights 127, spike_in=4'b1111 from voltage 0 -> syn_sum 127, next 126, fire, voltage 62.
REQ-031 SHALL test floor: voltage 20, all weights -100, spike_in=4'b1111 -> syn_sum -128, voltage 0, no spike.
REQ-032 SHALL test leak: voltage 5, spike_in=0 -> 4, 3, 2, 1, 0, then remains 0.
REQ-033 SHALL test enable gating: en=0 for 5 cycles mid-refractory -> voltage, counter and refrac_busy unchanged, spike_out=0.
REQ-034 SHALL test async reset: drop rstn between edges during REFRACTORY -> voltage=0, refrac_busy=0, spike_out=0 before the next clk edge.
